// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: queue entry layout, fetch FSM states, instruction size.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: an entry pushed in one cycle is at the registered head the next cycle.
// Push and pop together are allowed when full. A synchronous flush empties the queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output fetch_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop_eff;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_eff = pop & valid;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, queues {pc, word, fault} for decode, flushes on redirect,
// halts after queuing a fault entry for an illegal PC until redirect or reset.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IMEM_SIZE_BYTES = 1024,
  parameter int          FIFO_DEPTH      = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_SIZE_BYTES - INSTR_BYTES);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pc_legal;
  logic         q_full, q_valid, deq, enq;
  fetch_entry_t enq_entry, head;

  assign pc_legal    = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
  assign deq         = q_valid & instr_ready_i;
  assign imem_addr_o = pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = RUN;
    end else if (enq && !pc_legal) begin
      state_d = HALT;
    end
  end

  always_comb begin
    enq       = (state_q == RUN) && !redirect_i && (!q_full || deq);
    enq_entry = '{pc: pc_q, instr: 32'h0, fault: 1'b1};
    pc_d      = pc_q;
    if (pc_legal) begin
      enq_entry = '{pc: pc_q, instr: imem_rdata_i, fault: 1'b0};
    end
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (enq && pc_legal) begin
      pc_d = pc_q + 32'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .flush    (redirect_i),
    .push     (enq),
    .push_data(enq_entry),
    .pop      (deq),
    .full     (q_full),
    .valid    (q_valid),
    .head     (head)
  );

  // Storage is not reset, so head fields are forced to zero while the queue is empty.
  assign instr_valid_o = q_valid;
  assign instr_o       = q_valid ? head.instr : 32'h0;
  assign pc_o          = q_valid ? head.pc    : 32'h0;
  assign fault_o       = q_valid & head.fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte-addressed 1 KiB memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fault;

  logic [7:0]  mem [0:1023];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_o      (instr),
    .pc_o         (pc),
    .fault_o      (fault)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return 32'hA500_0000 | a;
    endcase
  endfunction

  always_comb begin
    imem_rdata = 32'h0;
    if (imem_addr <= 32'd1020) begin
      imem_rdata = {mem[imem_addr[9:0] + 10'd3], mem[imem_addr[9:0] + 10'd2],
                    mem[imem_addr[9:0] + 10'd1], mem[imem_addr[9:0]]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic head(input string tag, input logic [31:0] epc, input logic [31:0] einstr,
                      input logic efault);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".instr"}, instr, einstr);
    chk({tag, ".fault"}, 32'(fault), 32'(efault));
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    instr_ready = rdy;
    redirect = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target, input logic rdy);
    redirect = 1'b1;
    redirect_pc = target;
    instr_ready = rdy;
    cyc();
    redirect = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    for (int a = 0; a < 1024; a += 4) begin
      w = word_at(32'(a));
      mem[a]     = w[7:0];
      mem[a + 1] = w[15:8];
      mem[a + 2] = w[23:16];
      mem[a + 3] = w[31:24];
    end
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    @(negedge clk);

    // Reset state and streaming fetch
    do_reset(1'b1);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.instr", instr, 32'h0);
    chk("rst.pc", pc, 32'h0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.addr", imem_addr, 32'h0);
    cyc(); head("s0", 32'h0, 32'h0000_0013, 1'b0);
    chk("s0.addr", imem_addr, 32'h4);
    cyc(); head("s1", 32'h4, 32'h0010_0093, 1'b0);
    cyc(); head("s2", 32'h8, 32'h0020_0113, 1'b0);

    // Backpressure: queue fills with 0 and 4, PC parks at 8
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      head("bp.hold", 32'h0, 32'h0000_0013, 1'b0);
    end
    chk("bp.addr", imem_addr, 32'h8);
    instr_ready = 1'b1;
    head("bp.d0", 32'h0, 32'h0000_0013, 1'b0);
    cyc(); head("bp.d1", 32'h4, 32'h0010_0093, 1'b0);
    cyc(); head("bp.d2", 32'h8, 32'h0020_0113, 1'b0);
    cyc(); head("bp.d3", 32'hC, word_at(32'hC), 1'b0);

    // Redirect while queue holds 4 and 8
    do_reset(1'b0);
    cyc(); cyc();
    instr_ready = 1'b1;
    cyc();
    head("rd.pre", 32'h4, 32'h0010_0093, 1'b0);
    do_redirect(32'h40, 1'b0);
    chk("rd.valid", 32'(instr_valid), 32'd0);
    chk("rd.addr", imem_addr, 32'h40);
    instr_ready = 1'b1;
    cyc(); head("rd.new", 32'h40, word_at(32'h40), 1'b0);

    // Last legal word, then out-of-range fault and halt
    do_redirect(32'h3FC, 1'b1);
    chk("end.gap", 32'(instr_valid), 32'd0);
    cyc(); head("end.last", 32'h3FC, word_at(32'h3FC), 1'b0);
    cyc(); head("end.fault", 32'h400, 32'h0, 1'b1);
    cyc();
    chk("end.halt.valid", 32'(instr_valid), 32'd0);
    chk("end.halt.addr", imem_addr, 32'h400);
    cyc();
    chk("end.halt2.valid", 32'(instr_valid), 32'd0);
    chk("end.halt2.addr", imem_addr, 32'h400);

    // Misaligned redirect, then recovery
    do_redirect(32'h22, 1'b1);
    cyc(); head("mis.fault", 32'h22, 32'h0, 1'b1);
    cyc();
    chk("mis.halt.valid", 32'(instr_valid), 32'd0);
    chk("mis.halt.addr", imem_addr, 32'h22);
    do_redirect(32'h10, 1'b1);
    cyc(); head("rec.0", 32'h10, word_at(32'h10), 1'b0);
    cyc(); head("rec.1", 32'h14, word_at(32'h14), 1'b0);

    // Reset while full and halted
    do_redirect(32'h3FC, 1'b0);
    cyc(); cyc(); cyc();
    head("fh.head", 32'h3FC, word_at(32'h3FC), 1'b0);
    chk("fh.addr", imem_addr, 32'h400);
    do_reset(1'b1);
    chk("fh.rst.valid", 32'(instr_valid), 32'd0);
    chk("fh.rst.addr", imem_addr, 32'h0);
    cyc(); head("fh.run", 32'h0, 32'h0000_0013, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
